// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory arbiter: FSM states, owner codes and
// the store payload latched at grant time.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } store_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Owner selection for the memory arbiter: MEM wins unless IF has been passed
// over STARVE_LIMIT times in a row; also produces the next starvation count.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SC_W         = 3
) (
    input  logic            if_req_i,
    input  logic            mem_req_i,
    input  logic [SC_W-1:0] starve_cnt_i,
    output logic            owner_o,
    output logic [SC_W-1:0] starve_cnt_o
);

    logic if_starved;

    always_comb begin
        if_starved   = if_req_i && (starve_cnt_i == SC_W'(STARVE_LIMIT));
        owner_o      = (mem_req_i && !if_starved) ? OWNER_MEM : OWNER_IF;
        starve_cnt_o = starve_cnt_i;
        if (owner_o == OWNER_IF) begin
            starve_cnt_o = '0;
        end else if (if_req_i && !if_starved) begin
            starve_cnt_o = starve_cnt_i + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data memory, one
// transaction at a time, with MEM priority, IF starvation guard and a watchdog.
//
//   state | meaning
//   IDLE  | waiting for a request; owner and payload latched on grant
//   ISSUE | one-cycle request pulse to memory
//   WAIT  | holding address/data until reply or watchdog expiry
//   RESP  | one-cycle reply pulse to the owner
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_rep_o,
    output logic [DATA_W-1:0] if_rep_data_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_write_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [3:0]        mem_wmask_i,
    output logic              mem_rep_o,
    output logic [DATA_W-1:0] mem_rep_data_o,
    output logic              ms_req_o,
    output logic [ADDR_W-1:0] ms_addr_o,
    output logic              ms_write_o,
    output logic [31:0]       ms_wdata_o,
    output logic [3:0]        ms_wmask_o,
    input  logic              ms_rep_i,
    input  logic [DATA_W-1:0] ms_rep_data_i,
    output logic              timeout_o
);

    localparam int SC_W    = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WD_EN   = (TIMEOUT != 0);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    store_t            store_q, store_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              ms_req_q, ms_req_d;
    logic              ms_write_q, ms_write_d;
    logic              if_rep_q, if_rep_d;
    logic              mem_rep_q, mem_rep_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              timeout_q, timeout_d;

    logic              pick_owner;
    logic [SC_W-1:0]   pick_starve;
    logic              finish;
    logic [DATA_W-1:0] reply_data;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SC_W         (SC_W)
    ) u_pick (
        .if_req_i     (if_req_i),
        .mem_req_i    (mem_req_i),
        .starve_cnt_i (starve_q),
        .owner_o      (pick_owner),
        .starve_cnt_o (pick_starve)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        store_d    = store_q;
        starve_d   = starve_q;
        wd_d       = wd_q;
        ms_req_d   = 1'b0;
        ms_write_d = 1'b0;
        if_rep_d   = 1'b0;
        mem_rep_d  = 1'b0;
        if_data_d  = '0;
        mem_data_d = '0;
        timeout_d  = 1'b0;
        finish     = 1'b0;
        reply_data = '0;

        case (state_q)
            ARB_IDLE: begin
                if (if_req_i || mem_req_i) begin
                    state_d  = ARB_ISSUE;
                    owner_d  = pick_owner;
                    starve_d = pick_starve;
                    ms_req_d = 1'b1;
                    if (pick_owner == OWNER_MEM) begin
                        addr_d        = mem_addr_i;
                        store_d.write = mem_write_i;
                        store_d.wdata = mem_wdata_i;
                        store_d.wmask = mem_wmask_i;
                    end else begin
                        addr_d  = if_addr_i;
                        store_d = '0;
                    end
                    ms_write_d = store_d.write;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
                wd_d    = WD_W'(WD_LOAD);
            end
            ARB_WAIT: begin
                // A reply in the expiry cycle still counts as a real reply.
                if (ms_rep_i) begin
                    finish     = 1'b1;
                    reply_data = store_q.write ? '0 : ms_rep_data_i;
                end else if (WD_EN && (wd_q == '0)) begin
                    finish    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
                if (finish) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWNER_MEM) begin
                        mem_rep_d  = 1'b1;
                        mem_data_d = reply_data;
                    end else begin
                        if_rep_d  = 1'b1;
                        if_data_d = reply_data;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_IF;
            addr_q     <= '0;
            store_q    <= '0;
            starve_q   <= '0;
            wd_q       <= '0;
            ms_req_q   <= 1'b0;
            ms_write_q <= 1'b0;
            if_rep_q   <= 1'b0;
            mem_rep_q  <= 1'b0;
            if_data_q  <= '0;
            mem_data_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            starve_q   <= starve_d;
            wd_q       <= wd_d;
            ms_req_q   <= ms_req_d;
            ms_write_q <= ms_write_d;
            if_rep_q   <= if_rep_d;
            mem_rep_q  <= mem_rep_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ms_req_o       = ms_req_q;
    assign ms_addr_o      = addr_q;
    assign ms_write_o     = ms_write_q;
    assign ms_wdata_o     = store_q.wdata;
    assign ms_wmask_o     = store_q.wmask;
    assign if_rep_o       = if_rep_q;
    assign if_rep_data_o  = if_data_q;
    assign mem_rep_o      = mem_rep_q;
    assign mem_rep_data_o = mem_data_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a timestamp-based transaction model.
module tb_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_rep_o;
    logic [DATA_W-1:0] if_rep_data_o;
    logic              mem_req_i = 1'b0;
    logic [ADDR_W-1:0] mem_addr_i = '0;
    logic              mem_write_i = 1'b0;
    logic [31:0]       mem_wdata_i = '0;
    logic [3:0]        mem_wmask_i = '0;
    logic              mem_rep_o;
    logic [DATA_W-1:0] mem_rep_data_o;
    logic              ms_req_o;
    logic [ADDR_W-1:0] ms_addr_o;
    logic              ms_write_o;
    logic [31:0]       ms_wdata_o;
    logic [3:0]        ms_wmask_o;
    logic              ms_rep_i = 1'b0;
    logic [DATA_W-1:0] ms_rep_data_i = '0;
    logic              timeout_o;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_rep_o       (if_rep_o),
        .if_rep_data_o  (if_rep_data_o),
        .mem_req_i      (mem_req_i),
        .mem_addr_i     (mem_addr_i),
        .mem_write_i    (mem_write_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_wmask_i    (mem_wmask_i),
        .mem_rep_o      (mem_rep_o),
        .mem_rep_data_o (mem_rep_data_o),
        .ms_req_o       (ms_req_o),
        .ms_addr_o      (ms_addr_o),
        .ms_write_o     (ms_write_o),
        .ms_wdata_o     (ms_wdata_o),
        .ms_wmask_o     (ms_wmask_o),
        .ms_rep_i       (ms_rep_i),
        .ms_rep_data_i  (ms_rep_data_i),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void chk_str(string nm, string act, string exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endfunction

    // Memory responder: replies a fixed or random number of cycles after ms_req_o.
    int          rsp_cd = 0;
    int          lat_fixed = 1;
    bit          rand_mode = 1'b0;
    logic [63:0] rdata_fixed = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ms_rep_i      = 1'b0;
            ms_rep_data_i = rand_mode ? {$urandom, $urandom} : 64'h0;
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    ms_rep_i      = 1'b1;
                    ms_rep_data_i = rand_mode ? {$urandom, $urandom} : rdata_fixed;
                end
            end else if (rand_mode && $urandom_range(0, 19) == 0) begin
                ms_rep_i = 1'b1;
            end
            if (ms_req_o)
                rsp_cd = rand_mode ? int'($urandom_range(0, 11)) : lat_fixed;
        end
    end

    // Transaction model: a grant at cycle g issues at g+1, may be answered in
    // g+2..g+1+TIMEOUT, and reports one cycle after the answer or expiry.
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_t = 0;
    int          m_g = 0;
    int          m_r = -1;
    bit          m_mem = 1'b0;
    bit          m_write = 1'b0;
    bit          m_to = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wmask = '0;
    logic [63:0] m_rdata = '0;
    int          m_streak = 0;
    bit          e_issue;
    bit          e_resp;
    bit          m_pick_if;

    initial begin
        forever begin
            @(negedge clk);
            m_t++;
            if (m_valid) begin
                e_issue = m_busy && (m_t == m_g + 1);
                e_resp  = m_busy && (m_t == m_r);
                chk("ms_req", ms_req_o, e_issue);
                chk("ms_write", ms_write_o, e_issue && m_write);
                if (m_busy && m_t >= m_g + 1 && (m_r < 0 || m_t < m_r)) begin
                    chk("ms_addr", ms_addr_o, m_addr);
                    if (m_mem) begin
                        chk("ms_wdata", ms_wdata_o, m_wdata);
                        chk("ms_wmask", ms_wmask_o, m_wmask);
                    end
                end
                chk("if_rep", if_rep_o, e_resp && !m_mem);
                chk("if_data", if_rep_data_o, (e_resp && !m_mem) ? m_rdata : 64'h0);
                chk("mem_rep", mem_rep_o, e_resp && m_mem);
                chk("mem_data", mem_rep_data_o, (e_resp && m_mem) ? m_rdata : 64'h0);
                chk("timeout", timeout_o, e_resp && m_to);
            end
            if (rst) begin
                m_valid  = 1'b1;
                m_busy   = 1'b0;
                m_streak = 0;
            end else if (m_valid) begin
                if (m_busy) begin
                    if (m_r < 0 && m_t >= m_g + 2) begin
                        if (ms_rep_i) begin
                            m_r     = m_t + 1;
                            m_to    = 1'b0;
                            m_rdata = m_write ? 64'h0 : ms_rep_data_i;
                        end else if (TIMEOUT != 0 && m_t == m_g + 1 + TIMEOUT) begin
                            m_r     = m_t + 1;
                            m_to    = 1'b1;
                            m_rdata = 64'h0;
                        end
                    end else if (m_t == m_r) begin
                        m_busy = 1'b0;
                    end
                end else if (if_req_i || mem_req_i) begin
                    m_pick_if = if_req_i && (!mem_req_i || m_streak == STARVE_LIMIT);
                    m_busy    = 1'b1;
                    m_g       = m_t;
                    m_r       = -1;
                    m_mem     = !m_pick_if;
                    if (m_pick_if) begin
                        m_streak = 0;
                        m_addr   = if_addr_i;
                        m_write  = 1'b0;
                    end else begin
                        if (if_req_i) m_streak++;
                        m_addr  = mem_addr_i;
                        m_write = mem_write_i;
                        m_wdata = mem_wdata_i;
                        m_wmask = mem_wmask_i;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i    = 1'b0;
        mem_req_i   = 1'b0;
        mem_write_i = 1'b0;
        mem_wdata_i = '0;
        mem_wmask_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic run_seq(input int cycles, input bit mem_again, input bit if_again,
                           output string seq, output int nreq);
        seq  = "";
        nreq = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            nreq += int'(ms_req_o);
            if (mem_rep_o) seq = {seq, "M"};
            if (if_rep_o)  seq = {seq, "I"};
            if (mem_req_i && mem_rep_o) mem_req_i = 1'b0;
            else if (!mem_req_i && mem_again) mem_req_i = 1'b1;
            if (if_req_i && if_rep_o) if_req_i = 1'b0;
            else if (!if_req_i && if_again) if_req_i = 1'b1;
        end
    endtask

    string seq;
    int    nreq;
    int    pct;

    initial begin
        do_reset();
        chk("rst_ms_req", ms_req_o, 1'b0);
        chk("rst_ms_addr", ms_addr_o, 32'h0);
        chk("rst_if_rep", if_rep_o, 1'b0);
        chk("rst_mem_rep", mem_rep_o, 1'b0);
        chk("rst_timeout", timeout_o, 1'b0);

        // IF only, memory answers one cycle after the request pulse.
        lat_fixed = 1; rdata_fixed = 64'hAABB;
        tick(); if_req_i = 1'b1; if_addr_i = 32'h10;
        tick(); chk("t1_ms_req", ms_req_o, 1'b1); chk("t1_ms_addr", ms_addr_o, 32'h10);
        tick(); chk("t1_wait_rep", if_rep_o, 1'b0);
        tick(); chk("t1_if_rep", if_rep_o, 1'b1); chk("t1_if_data", if_rep_data_o, 64'hAABB);
        chk("t1_mem_rep", mem_rep_o, 1'b0); if_req_i = 1'b0;
        tick(); chk("t1_rep_clr", if_rep_o, 1'b0); chk("t1_data_clr", if_rep_data_o, 64'h0);

        // Simultaneous single requests: MEM first, then IF.
        do_reset();
        if_req_i = 1'b1; if_addr_i = 32'h100; mem_req_i = 1'b1; mem_addr_i = 32'h200;
        run_seq(20, 1'b0, 1'b0, seq, nreq);
        chk_str("t2_order", seq, "MI");
        chk("t2_ms_req_count", 32'(nreq), 32'd2);

        // MEM keeps requesting, IF waits: four MEM grants then one IF.
        do_reset();
        if_req_i = 1'b1; mem_req_i = 1'b1;
        run_seq(60, 1'b1, 1'b1, seq, nreq);
        chk_str("t3_starve", seq.substr(0, 9), "MMMMIMMMMI");
        idle_inputs();
        repeat (6) tick();

        // MEM store.
        do_reset();
        rdata_fixed = 64'hDEAD_BEEF_0000_1234;
        tick(); mem_req_i = 1'b1; mem_write_i = 1'b1; mem_addr_i = 32'h20;
        mem_wdata_i = 32'h1122_3344; mem_wmask_i = 4'b0011;
        tick(); chk("t4_ms_req", ms_req_o, 1'b1); chk("t4_ms_write", ms_write_o, 1'b1);
        chk("t4_addr", ms_addr_o, 32'h20); chk("t4_wdata", ms_wdata_o, 32'h1122_3344);
        chk("t4_wmask", ms_wmask_o, 4'b0011);
        tick(); chk("t4_write_pulse", ms_write_o, 1'b0);
        tick(); chk("t4_mem_rep", mem_rep_o, 1'b1); chk("t4_store_data", mem_rep_data_o, 64'h0);
        idle_inputs();
        tick();

        // Silent memory: watchdog fires, later reply is ignored.
        lat_fixed = 10; rdata_fixed = 64'h5555;
        tick(); mem_req_i = 1'b1; mem_addr_i = 32'h30;
        tick(); chk("t5_ms_req", ms_req_o, 1'b1);
        repeat (8) tick();
        chk("t5_no_early_rep", mem_rep_o, 1'b0);
        tick(); chk("t5_mem_rep", mem_rep_o, 1'b1); chk("t5_timeout", timeout_o, 1'b1);
        chk("t5_data", mem_rep_data_o, 64'h0); mem_req_i = 1'b0;
        tick(); chk("t5_timeout_clr", timeout_o, 1'b0); chk("t5_late_rep_in", ms_rep_i, 1'b1);
        tick(); chk("t5_late_ignored", mem_rep_o, 1'b0); chk("t5_no_reissue", ms_req_o, 1'b0);

        // Reset during WAIT.
        lat_fixed = 3;
        tick(); mem_req_i = 1'b1; mem_addr_i = 32'h40;
        tick(); chk("t6_ms_req", ms_req_o, 1'b1);
        tick(); rst = 1'b1; mem_req_i = 1'b0;
        tick(); rst = 1'b0;
        chk("t6_ms_addr", ms_addr_o, 32'h0); chk("t6_ms_req0", ms_req_o, 1'b0);
        chk("t6_mem_rep0", mem_rep_o, 1'b0); chk("t6_timeout0", timeout_o, 1'b0);
        tick(); chk("t6_reply_in", ms_rep_i, 1'b1);
        tick(); chk("t6_no_rep", mem_rep_o, 1'b0); chk("t6_no_if_rep", if_rep_o, 1'b0);

        // Randomized traffic checked by the model every cycle.
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            pct = (i < 2000) ? 70 : 25;
            if (if_req_i && if_rep_o) begin
                if_req_i = 1'b0;
            end else if (!if_req_i && int'($urandom_range(0, 99)) < pct) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom;
            end
            if (mem_req_i && mem_rep_o) begin
                mem_req_i = 1'b0;
            end else if (!mem_req_i && int'($urandom_range(0, 99)) < pct) begin
                mem_req_i   = 1'b1;
                mem_addr_i  = $urandom;
                mem_write_i = 1'($urandom_range(0, 1));
                mem_wdata_i = $urandom;
                mem_wmask_i = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 499) == 0);
            if (rst) begin
                if_req_i  = 1'b0;
                mem_req_i = 1'b0;
            end
        end
        rst = 1'b0;
        rand_mode = 1'b0;
        idle_inputs();
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
